// File: rtl/conv_bf16tomxi_stream.sv
// Streaming bf16 -> MXINT converter: assembles K-element blocks over K/LANES beats,
// derives the shared E8M0 scale and quantises into a double-buffered output stage.
module conv_bf16tomxi_stream #(
    parameter int BIT_WIDTH  = 8,
    parameter int K          = 32,
    parameter int LANES      = 8,
    parameter int ROUND_MODE = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [LANES*16-1:0]           i_bf16_vec,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic signed [K*BIT_WIDTH-1:0] o_mx_vec,
    output logic [7:0]                    o_mx_exp
);
    localparam int BEATS   = K / LANES;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int MAG_MAX = (1 << (BIT_WIDTH - 1)) - 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Truncation keeps the integer part; RNE uses guard/sticky then clamps so -2^(W-1) never appears.
    function automatic logic [8:0] rnd_sat(input logic [7:0] int_part, input logic guard,
                                           input logic sticky);
        logic [8:0] mag;
        mag = {1'b0, int_part};
        if (ROUND_MODE == 1) begin
            if (guard && (sticky || int_part[0])) mag = mag + 9'd1;
            if (mag > 9'(MAG_MAX)) mag = 9'(MAG_MAX);
        end
        return mag;
    endfunction

    function automatic logic signed [BIT_WIDTH-1:0] quant_elem(input logic [15:0] bf,
                                                                input logic [7:0]  scale);
        logic [8:0]           shamt;
        logic [17:0]          aligned;
        logic [8:0]           mag;
        logic [BIT_WIDTH-1:0] mag_w;
        shamt   = 9'(scale - bf[14:7]) + 9'(9 - BIT_WIDTH);
        aligned = {1'b1, bf[6:0], 10'd0} >> shamt;
        mag     = rnd_sat(aligned[17:10], aligned[9], |aligned[8:0]);
        mag_w   = mag[BIT_WIDTH-1:0];
        if (scale == 8'hFF || bf[14:7] == 8'd0) mag_w = '0;
        return bf[15] ? -mag_w : mag_w;
    endfunction

    logic [K*16-1:0]        asm_buf_p0;
    logic [CNT_W-1:0]       beat_cnt_p0;
    logic [7:0]             run_max_p0;
    logic                   nan_p0;
    logic                   vld_p0;
    logic                   vld_p1;
    logic [K*BIT_WIDTH-1:0] mx_vec_p1;
    logic [7:0]             mx_exp_p1;
    logic                   accept, xfer, last_beat, beat_nan;
    logic [7:0]             beat_max, lane_exp, scale;
    logic [K*BIT_WIDTH-1:0] q_vec;

    assign xfer      = vld_p0 && (!vld_p1 || i_ready);
    assign o_ready   = !vld_p0 || xfer;
    assign accept    = i_valid && o_ready;
    assign last_beat = (beat_cnt_p0 == LAST_BEAT);
    assign scale     = nan_p0 ? 8'hFF : run_max_p0;

    always_comb begin
        beat_max = 8'd0;
        beat_nan = 1'b0;
        lane_exp = 8'd0;
        for (int j = 0; j < LANES; j++) begin
            lane_exp = i_bf16_vec[j*16+7 +: 8];
            if (lane_exp > beat_max) beat_max = lane_exp;
            if (lane_exp == 8'hFF) beat_nan = 1'b1;
        end
    end

    // ---- stage p0: block assembly ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_cnt_p0 <= '0;
            run_max_p0  <= 8'd0;
            nan_p0      <= 1'b0;
            vld_p0      <= 1'b0;
        end else begin
            if (accept) beat_cnt_p0 <= last_beat ? '0 : beat_cnt_p0 + 1'b1;
            if (xfer) begin
                run_max_p0 <= accept ? beat_max : 8'd0;
                nan_p0     <= accept && beat_nan;
            end else if (accept) begin
                run_max_p0 <= (beat_max > run_max_p0) ? beat_max : run_max_p0;
                nan_p0     <= nan_p0 | beat_nan;
            end
            if (accept && last_beat) vld_p0 <= 1'b1;
            else if (xfer)           vld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < BEATS; b++) begin
            if (accept && beat_cnt_p0 == CNT_W'(b))
                asm_buf_p0[b*LANES*16 +: LANES*16] <= i_bf16_vec;
        end
    end

    always_comb begin
        q_vec = '0;
        for (int i = 0; i < K; i++)
            q_vec[i*BIT_WIDTH +: BIT_WIDTH] = quant_elem(asm_buf_p0[i*16 +: 16], scale);
    end

    // ---- stage p1: output holding register ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1    <= 1'b0;
            mx_vec_p1 <= '0;
            mx_exp_p1 <= 8'd0;
        end else if (xfer) begin
            vld_p1    <= 1'b1;
            mx_vec_p1 <= q_vec;
            mx_exp_p1 <= scale;
        end else if (i_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    assign o_valid  = vld_p1;
    assign o_mx_vec = mx_vec_p1;
    assign o_mx_exp = mx_exp_p1;
endmodule

// File: tb/tb_conv_bf16tomxi_stream.sv
// Bench for conv_bf16tomxi_stream: five element-width/rounding variants share one
// stimulus stream and are compared every cycle against a real-arithmetic block model.
`timescale 1ns/1ps
module tb_conv_bf16tomxi_stream;
    localparam int K     = 32;
    localparam int LANES = 8;
    localparam int BEATS = K / LANES;
    localparam int NCFG  = 5;
    localparam int CFG_BW [NCFG] = '{8, 8, 4, 6, 9};
    localparam int CFG_RM [NCFG] = '{0, 1, 1, 0, 1};
    localparam int NBLK  = 1500;

    typedef logic [K*16-1:0] blk_t;
    typedef logic [K*9-1:0]  wide_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_valid = 1'b0;
    logic               i_ready = 1'b1;
    logic [LANES*16-1:0] i_bf16_vec = '0;
    logic [NCFG-1:0]    rdy, ov;
    logic [7:0]         oexp [NCFG];
    wide_t              mxv  [NCFG];

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;
    bit rnd_ready = 0;

    logic [15:0] m_asm[$];
    blk_t        m_pend, m_out;
    bit          m_pend_v = 0;
    bit          m_out_v  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int BW = CFG_BW[g];
        logic [K*BW-1:0] vec;
        conv_bf16tomxi_stream #(.BIT_WIDTH(BW), .K(K), .LANES(LANES), .ROUND_MODE(CFG_RM[g])) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy[g]),
            .i_bf16_vec(i_bf16_vec), .o_valid(ov[g]), .i_ready(i_ready),
            .o_mx_vec(vec), .o_mx_exp(oexp[g]));
        assign mxv[g] = wide_t'(vec);
    end

    // Reference: element = sig * 2^(exp - scale + bw - 9), rounded per mode in real arithmetic.
    function automatic int model_q(input logic [15:0] bf, input int scale, input int bw, input int rm);
        int  e, q;
        real x, fl, frac;
        e = int'(bf[14:7]);
        if (scale == 255 || e == 0) return 0;
        x    = real'(128 + int'(bf[6:0])) * (2.0 ** real'(e - scale + bw - 9));
        fl   = $floor(x);
        q    = $rtoi(fl);
        frac = x - fl;
        if (rm == 1) begin
            if (frac > 0.5 || (frac == 0.5 && (q % 2) == 1)) q++;
            if (q > (1 << (bw - 1)) - 1) q = (1 << (bw - 1)) - 1;
        end
        return bf[15] ? -q : q;
    endfunction

    function automatic int model_scale(input blk_t b);
        int m = 0;
        for (int i = 0; i < K; i++) begin
            int e = int'(b[i*16+7 +: 8]);
            if (e == 255) return 255;
            if (e > m) m = e;
        end
        return m;
    endfunction

    function automatic wide_t model_vec(input blk_t b, input int bw, input int rm);
        wide_t r = '0;
        int s = model_scale(b);
        for (int i = 0; i < K; i++) begin
            int q = model_q(b[i*16 +: 16], s, bw, rm) & ((1 << bw) - 1);
            r = r | (wide_t'(q) << (i * bw));
        end
        return r;
    endfunction

    function automatic int elem(input int g, input int i);
        int    bw = CFG_BW[g];
        wide_t t  = mxv[g] >> (i * bw);
        int    v  = int'(t[8:0]) & ((1 << bw) - 1);
        if (v >= (1 << (bw - 1))) v = v - (1 << bw);
        return v;
    endfunction

    task automatic chk(input string name, input wide_t act, input wide_t req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic chk_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout, expected handshake", name);
    endtask

    // Transaction model: assembly queue, one pending block, one output block.
    initial begin
        bit   xf, rd;
        blk_t nb;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_asm.delete();
                m_pend_v = 0;
                m_out_v  = 0;
            end else begin
                xf = m_pend_v && (!m_out_v || i_ready);
                rd = !m_pend_v || xf;
                if (xf) begin
                    m_out    = m_pend;
                    m_out_v  = 1;
                    m_pend_v = 0;
                end else if (m_out_v && i_ready) begin
                    m_out_v = 0;
                end
                if (i_valid && rd) begin
                    for (int j = 0; j < LANES; j++) m_asm.push_back(i_bf16_vec[j*16 +: 16]);
                    if (m_asm.size() == K) begin
                        for (int i = 0; i < K; i++) nb[i*16 +: 16] = m_asm[i];
                        m_pend   = nb;
                        m_pend_v = 1;
                        m_asm.delete();
                    end
                end
            end
        end
    end

    initial begin
        bit erdy;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                erdy = !m_pend_v || !m_out_v || i_ready;
                for (int g = 0; g < NCFG; g++) begin
                    chk($sformatf("cfg%0d o_ready", g), wide_t'(rdy[g]), wide_t'(erdy));
                    chk($sformatf("cfg%0d o_valid", g), wide_t'(ov[g]), wide_t'(m_out_v));
                    if (m_out_v) begin
                        chk($sformatf("cfg%0d o_mx_exp", g), wide_t'(oexp[g]), wide_t'(model_scale(m_out)));
                        chk($sformatf("cfg%0d o_mx_vec", g), mxv[g], model_vec(m_out, CFG_BW[g], CFG_RM[g]));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_ready) i_ready = ($urandom % 3 != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_beat(input logic [LANES*16-1:0] v);
        bit acc = 0;
        int n   = 0;
        i_valid    = 1'b1;
        i_bf16_vec = v;
        while (!acc) begin
            @(negedge clk);
            acc = rdy[0];
            tick();
            n++;
            if (!acc && n > 500) begin
                chk_fail("beat accept");
                break;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic send_block(input blk_t b, input bit gaps);
        for (int k = 0; k < BEATS; k++) begin
            if (gaps && ($urandom % 4 == 0)) repeat ($urandom_range(1, 3)) tick();
            send_beat(b[k*LANES*16 +: LANES*16]);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        forever begin
            @(negedge clk);
            if (ov[0]) break;
            n++;
            if (n > 50) begin
                chk_fail("output valid");
                break;
            end
        end
    endtask

    function automatic blk_t fill(input logic [15:0] v);
        blk_t b;
        for (int i = 0; i < K; i++) b[i*16 +: 16] = v;
        return b;
    endfunction

    function automatic blk_t rnd_block();
        blk_t b;
        int   base = $urandom_range(1, 230);
        for (int i = 0; i < K; i++) begin
            logic [15:0] r;
            r[15]  = 1'($urandom);
            r[6:0] = 7'($urandom);
            if ($urandom % 8 == 0)       r[14:7] = 8'd0;
            else if ($urandom % 16 == 0) r[14:7] = 8'($urandom_range(1, 254));
            else                         r[14:7] = 8'(base + $urandom_range(0, 20));
            b[i*16 +: 16] = r;
        end
        if ($urandom % 12 == 0) b[$urandom_range(0, K - 1)*16 +: 16] = ($urandom % 2) ? 16'h7FC0 : 16'hFF80;
        return b;
    endfunction

    initial begin
        blk_t b;
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        blk_t b;
        // Pin the reference model on hand-computed values.
        chk("model 1.0", wide_t'(model_q(16'h3F80, 127, 8, 0)), wide_t'(64));
        chk("model -1.5", wide_t'(model_q(16'hBFC0, 127, 8, 0)), wide_t'(-96));
        chk("model trunc 1.5lsb", wide_t'(model_q(16'h3CC0, 127, 8, 0)), wide_t'(1));
        chk("model rne 1.5lsb", wide_t'(model_q(16'h3CC0, 127, 8, 1)), wide_t'(2));
        chk("model trunc .75lsb", wide_t'(model_q(16'h3C40, 127, 8, 0)), wide_t'(0));
        chk("model rne .75lsb", wide_t'(model_q(16'h3C40, 127, 8, 1)), wide_t'(1));
        chk("model rne sat", wide_t'(model_q(16'h3FFF, 127, 8, 1)), wide_t'(127));
        chk("model denorm", wide_t'(model_q(16'h0045, 127, 8, 1)), wide_t'(0));

        repeat (2) tick();
        chk_en = 1;
        @(negedge clk);
        for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("cfg%0d reset o_valid", g), wide_t'(ov[g]), '0);
            chk($sformatf("cfg%0d reset o_mx_exp", g), wide_t'(oexp[g]), '0);
            chk($sformatf("cfg%0d reset o_mx_vec", g), mxv[g], '0);
        end
        tick();
        rst_n = 1'b1;
        tick();

        // Basic block with exact latency.
        b = '0;
        b[0*16 +: 16] = 16'h3F80;
        b[1*16 +: 16] = 16'h3F00;
        b[2*16 +: 16] = 16'hBFC0;
        send_block(b, 0);
        @(negedge clk);
        chk("basic valid before N+1", wide_t'(ov[0]), '0);
        @(negedge clk);
        chk("basic valid after N+1", wide_t'(ov[0]), wide_t'(1));
        chk("basic scale", wide_t'(oexp[0]), wide_t'(127));
        chk("basic e0", wide_t'(elem(0, 0)), wide_t'(64));
        chk("basic e1", wide_t'(elem(0, 1)), wide_t'(32));
        chk("basic e2", wide_t'(elem(0, 2)), wide_t'(-96));
        chk("basic e5", wide_t'(elem(0, 5)), wide_t'(0));
        tick();

        // Rounding per mode.
        b = '0;
        b[0*16 +: 16] = 16'h3F80;
        b[1*16 +: 16] = 16'h3CC0;
        b[2*16 +: 16] = 16'h3C40;
        b[3*16 +: 16] = 16'h3FFF;
        send_block(b, 0);
        wait_valid();
        chk("trunc e1", wide_t'(elem(0, 1)), wide_t'(1));
        chk("trunc e2", wide_t'(elem(0, 2)), wide_t'(0));
        chk("trunc e3", wide_t'(elem(0, 3)), wide_t'(127));
        chk("rne e1", wide_t'(elem(1, 1)), wide_t'(2));
        chk("rne e2", wide_t'(elem(1, 2)), wide_t'(1));
        chk("rne e3", wide_t'(elem(1, 3)), wide_t'(127));
        tick();

        // NaN, Inf, denormal, all-denormal.
        b = fill(16'h3F80);
        b[5*16 +: 16] = 16'h7FC0;
        send_block(b, 0);
        wait_valid();
        chk("nan scale", wide_t'(oexp[0]), wide_t'(255));
        chk("nan elems", mxv[0], '0);
        tick();
        b = fill(16'h3F80);
        b[30*16 +: 16] = 16'h7F80;
        send_block(b, 0);
        wait_valid();
        chk("inf scale", wide_t'(oexp[2]), wide_t'(255));
        chk("inf elems", mxv[2], '0);
        tick();
        b = '0;
        b[0*16 +: 16] = 16'h3F80;
        b[1*16 +: 16] = 16'h0045;
        send_block(b, 0);
        wait_valid();
        chk("denorm scale", wide_t'(oexp[0]), wide_t'(127));
        chk("denorm elem", wide_t'(elem(0, 1)), wide_t'(0));
        tick();
        send_block(fill(16'h8045), 0);
        wait_valid();
        chk("all-denorm scale", wide_t'(oexp[0]), wide_t'(0));
        tick();

        // Backpressure: two blocks streamed while the consumer stalls.
        i_ready = 1'b0;
        send_block(fill(16'h4000), 0);
        send_block(fill(16'h3E00), 0);
        repeat (2) tick();
        @(negedge clk);
        chk("bp o_ready low", wide_t'(rdy[0]), '0);
        chk("bp block1 held", wide_t'(oexp[0]), wide_t'(128));
        tick();
        i_ready = 1'b1;
        @(negedge clk);
        chk("bp block1 still out", wide_t'(oexp[0]), wide_t'(128));
        @(negedge clk);
        chk("bp block2 out", wide_t'(oexp[0]), wide_t'(124));
        chk("bp block2 valid", wide_t'(ov[0]), wide_t'(1));
        tick();
        repeat (2) tick();

        // Reset in the middle of a block.
        b = fill(16'h4780);
        send_beat(b[0 +: LANES*16]);
        send_beat(b[0 +: LANES*16]);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst o_valid", wide_t'(ov[0]), '0);
        chk("midrst o_ready", wide_t'(rdy[0]), wide_t'(1));
        tick();
        rst_n = 1'b1;
        tick();
        send_block(fill(16'h3E80), 0);
        wait_valid();
        chk("midrst fresh scale", wide_t'(oexp[0]), wide_t'(125));
        tick();

        // Randomised traffic with random valid gaps and ready stalls.
        rnd_ready = 1;
        for (int n = 0; n < NBLK; n++) send_block(rnd_block(), 1);
        rnd_ready = 0;
        i_ready   = 1'b1;
        repeat (10) tick();
        chk("drain empty", wide_t'(ov[0]), '0);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
